// File: rtl/byte_lane_ram.sv
// byte_lane_ram
//   Parametrised byte-lane RAM with a handshaked, byte-enabled load/store port
//   and an always-accepted instruction-fetch read port. After reset the array
//   is optionally zero-filled, one word per enabled cycle. Read responses
//   arrive READ_LATENCY enabled cycles after accept. Out-of-range accesses
//   raise error pulses with the same latency.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   clk_en                     global enable; 0 freezes every register
//   i_req/i_we/i_byte_enable   load/store request, store select, lane mask
//   i_addr/i_wdata             load/store word address and store data
//   o_ready                    load/store port can accept (RUN state)
//   o_rvalid/o_rdata/o_err     load response pulse, held data, range-error pulse
//   i_fetch_req/i_fetch_addr   fetch request and word address
//   o_fetch_valid/o_fetch_data/o_fetch_err  fetch response, held data, error
//   o_init_done                zero-fill finished (sticky until reset)
module byte_lane_ram #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DEPTH        = 1024,
    parameter int NUM_LANES    = 4,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 1,
    parameter int INIT_ZERO    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic                   i_req,
    input  logic                   i_we,
    input  logic [NUM_LANES-1:0]   i_byte_enable,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic [8*NUM_LANES-1:0] i_wdata,
    output logic                   o_ready,
    output logic                   o_rvalid,
    output logic [8*NUM_LANES-1:0] o_rdata,
    output logic                   o_err,
    input  logic                   i_fetch_req,
    input  logic [ADDR_WIDTH-1:0]  i_fetch_addr,
    output logic                   o_fetch_valid,
    output logic [8*NUM_LANES-1:0] o_fetch_data,
    output logic                   o_fetch_err,
    output logic                   o_init_done
);

    localparam int DW    = 8 * NUM_LANES;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_W  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] cnt, cnt_nx;
    logic             init_done_nx;
    logic             fill_we;

    logic [DW-1:0]    mem [DEPTH];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // With INIT_ZERO=0 the FSM still resets into ST_INIT so o_ready is 0
    // while in reset; it leaves on the first enabled cycle without writing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            cnt         <= '0;
            o_init_done <= 1'b0;
        end else if (clk_en) begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            o_init_done <= init_done_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        init_done_nx = o_init_done;
        fill_we      = 1'b0;
        case (state)
            ST_INIT: begin
                if (clk_en) begin
                    if (INIT_ZERO != 0) begin
                        fill_we = 1'b1;
                        if (cnt == LAST_W) begin
                            state_nx     = ST_RUN;
                            cnt_nx       = '0;
                            init_done_nx = 1'b1;
                        end else begin
                            cnt_nx = cnt + IDX_W'(1);
                        end
                    end else begin
                        state_nx     = ST_RUN;
                        init_done_nx = 1'b1;
                    end
                end
            end
            ST_RUN:  state_nx = ST_RUN;
            default: state_nx = ST_INIT;
        endcase
    end

    assign o_ready = (state == ST_RUN);

    // ------------------------------------------------------------------
    // Accept decode
    // ------------------------------------------------------------------
    logic             ls_acc, ld_acc, st_acc, fe_acc;
    logic             ls_oor, fe_oor;
    logic [IDX_W-1:0] ls_idx, fe_idx;

    assign ls_acc = i_req & o_ready & clk_en;
    assign ld_acc = ls_acc & ~i_we;
    assign st_acc = ls_acc & i_we;
    assign fe_acc = i_fetch_req & (state == ST_RUN) & clk_en;

    assign ls_oor = !({1'b0, i_addr} < DEPTH_L);
    assign fe_oor = !({1'b0, i_fetch_addr} < DEPTH_L);
    assign ls_idx = i_addr[IDX_W-1:0];
    assign fe_idx = i_fetch_addr[IDX_W-1:0];

    // ------------------------------------------------------------------
    // Storage (no reset on the array; the fill clears it instead)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[cnt] <= '0;
        end else if (st_acc && !ls_oor) begin
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                if (i_byte_enable[k]) begin
                    mem[ls_idx][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data selection
    // ------------------------------------------------------------------
    logic [DW-1:0] ld_word, fe_word;
    logic          fwd_hit;

    assign fwd_hit = (WRITE_FIRST != 0) && st_acc && !ls_oor && (i_addr == i_fetch_addr);

    always_comb begin
        ld_word = '0;
        if (!ls_oor) begin
            ld_word = mem[ls_idx];
        end
    end

    // Write-first forwarding merges the in-flight store's enabled lanes.
    always_comb begin
        fe_word = '0;
        if (!fe_oor) begin
            fe_word = mem[fe_idx];
            if (fwd_hit) begin
                for (int unsigned k = 0; k < NUM_LANES; k++) begin
                    if (i_byte_enable[k]) begin
                        fe_word[8*k +: 8] = i_wdata[8*k +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline, first stage
    // ------------------------------------------------------------------
    logic          s1_rvalid, s1_err, s1_fvalid, s1_ferr;
    logic [DW-1:0] s1_rdata, s1_fdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_rvalid <= 1'b0;
            s1_rdata  <= '0;
            s1_err    <= 1'b0;
            s1_fvalid <= 1'b0;
            s1_fdata  <= '0;
            s1_ferr   <= 1'b0;
        end else if (clk_en) begin
            s1_rvalid <= ld_acc;
            s1_err    <= ls_acc & ls_oor;
            s1_fvalid <= fe_acc;
            s1_ferr   <= fe_acc & fe_oor;
            if (ld_acc) begin
                s1_rdata <= ld_word;
            end
            if (fe_acc) begin
                s1_fdata <= fe_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional output register stage
    // ------------------------------------------------------------------
    generate
        if (READ_LATENCY == 2) begin : g_rl2
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    o_rvalid      <= 1'b0;
                    o_rdata       <= '0;
                    o_err         <= 1'b0;
                    o_fetch_valid <= 1'b0;
                    o_fetch_data  <= '0;
                    o_fetch_err   <= 1'b0;
                end else if (clk_en) begin
                    o_rvalid      <= s1_rvalid;
                    o_err         <= s1_err;
                    o_fetch_valid <= s1_fvalid;
                    o_fetch_err   <= s1_ferr;
                    if (s1_rvalid) begin
                        o_rdata <= s1_rdata;
                    end
                    if (s1_fvalid) begin
                        o_fetch_data <= s1_fdata;
                    end
                end
            end
        end else begin : g_rl1
            assign o_rvalid      = s1_rvalid;
            assign o_rdata       = s1_rdata;
            assign o_err         = s1_err;
            assign o_fetch_valid = s1_fvalid;
            assign o_fetch_data  = s1_fdata;
            assign o_fetch_err   = s1_ferr;
        end
    endgenerate

endmodule
